dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 105 ++++++++++
 tb/tb_dmem_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: CPU MEM stage vs. debug/dump port, with a
// starvation bound for debug and a locked-burst mode that hands memory to debug.
module dmem_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int AW         = 30
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          CPU_REQ,
  input  logic          CPU_WE,
  input  logic [3:0]    CPU_BE,
  input  logic [AW-1:0] CPU_ADDR,
  input  logic [31:0]   CPU_WDATA,
  output logic          CPU_GNT,
  output logic          CPU_STALL,
  output logic          CPU_RVALID,
  output logic [31:0]   CPU_RDATA,
  input  logic          DBG_REQ,
  input  logic          DBG_WE,
  input  logic          DBG_LOCK,
  input  logic [3:0]    DBG_BE,
  input  logic [AW-1:0] DBG_ADDR,
  input  logic [31:0]   DBG_WDATA,
  output logic          DBG_GNT,
  output logic          DBG_RVALID,
  output logic [31:0]   DBG_RDATA,
  output logic          MEM_RE,
  output logic          MEM_WE,
  output logic [3:0]    MEM_BE,
  output logic [AW-1:0] MEM_ADDR,
  output logic [31:0]   MEM_WDATA,
  input  logic [31:0]   MEM_RDATA,
  output logic [15:0]   CONFLICT_CNT
);
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic {ARB, DLOCK} state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] starve_cnt;
  logic          cpu_gnt, dbg_gnt;
  logic          cpu_rv, dbg_rv;
  logic [15:0]   conf_cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ARB;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB:     if (dbg_gnt && DBG_LOCK) state_nxt = DLOCK;
      DLOCK:   if (!DBG_REQ || !DBG_LOCK) state_nxt = ARB;
      default: state_nxt = ARB;
    endcase
  end

  // Grants are combinational so a lone requester is served in its request cycle.
  always_comb begin
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (!RST) begin
      case (state)
        ARB: begin
          if (DBG_REQ && (!CPU_REQ || starve_cnt == SW'(STARVE_MAX))) dbg_gnt = 1'b1;
          else if (CPU_REQ)                                           cpu_gnt = 1'b1;
        end
        DLOCK:   dbg_gnt = DBG_REQ;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      starve_cnt <= '0;
      conf_cnt   <= '0;
      cpu_rv     <= 1'b0;
      dbg_rv     <= 1'b0;
    end else begin
      if (dbg_gnt || !DBG_REQ)              starve_cnt <= '0;
      else if (starve_cnt != SW'(STARVE_MAX)) starve_cnt <= starve_cnt + SW'(1);
      if (CPU_REQ && DBG_REQ && conf_cnt != 16'hFFFF) conf_cnt <= conf_cnt + 16'd1;
      // Owner flag for the one-cycle read return path.
      cpu_rv <= cpu_gnt & ~CPU_WE;
      dbg_rv <= dbg_gnt & ~DBG_WE;
    end
  end

  assign CPU_GNT      = cpu_gnt;
  assign DBG_GNT      = dbg_gnt;
  assign CPU_STALL    = CPU_REQ & ~cpu_gnt;
  assign CPU_RVALID   = cpu_rv;
  assign DBG_RVALID   = dbg_rv;
  assign CPU_RDATA    = MEM_RDATA;
  assign DBG_RDATA    = MEM_RDATA;
  assign CONFLICT_CNT = conf_cnt;

  assign MEM_RE    = (cpu_gnt & ~CPU_WE) | (dbg_gnt & ~DBG_WE);
  assign MEM_WE    = (cpu_gnt &  CPU_WE) | (dbg_gnt &  DBG_WE);
  assign MEM_BE    = dbg_gnt ? DBG_BE    : CPU_BE;
  assign MEM_ADDR  = dbg_gnt ? DBG_ADDR  : CPU_ADDR;
  assign MEM_WDATA = dbg_gnt ? DBG_WDATA : CPU_WDATA;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: reset, CPU read/write, starvation rotation,
// debug lock bursts, reset mid-read and conflict counter saturation.
module tb_dmem_arbiter;
  localparam int AW = 30;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we;
  logic [3:0]    cpu_be;
  logic [AW-1:0] cpu_addr;
  logic [31:0]   cpu_wdata;
  logic          cpu_gnt, cpu_stall, cpu_rvalid;
  logic [31:0]   cpu_rdata;
  logic          dbg_req, dbg_we, dbg_lock;
  logic [3:0]    dbg_be;
  logic [AW-1:0] dbg_addr;
  logic [31:0]   dbg_wdata;
  logic          dbg_gnt, dbg_rvalid;
  logic [31:0]   dbg_rdata;
  logic          mem_re, mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic [15:0]   conflict_cnt;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_conf = 16'd0;

  always #5 clk = ~clk;

  dmem_arbiter #(.STARVE_MAX(4), .AW(AW)) dut (
    .CLK(clk), .RST(rst),
    .CPU_REQ(cpu_req), .CPU_WE(cpu_we), .CPU_BE(cpu_be), .CPU_ADDR(cpu_addr),
    .CPU_WDATA(cpu_wdata), .CPU_GNT(cpu_gnt), .CPU_STALL(cpu_stall),
    .CPU_RVALID(cpu_rvalid), .CPU_RDATA(cpu_rdata),
    .DBG_REQ(dbg_req), .DBG_WE(dbg_we), .DBG_LOCK(dbg_lock), .DBG_BE(dbg_be),
    .DBG_ADDR(dbg_addr), .DBG_WDATA(dbg_wdata), .DBG_GNT(dbg_gnt),
    .DBG_RVALID(dbg_rvalid), .DBG_RDATA(dbg_rdata),
    .MEM_RE(mem_re), .MEM_WE(mem_we), .MEM_BE(mem_be), .MEM_ADDR(mem_addr),
    .MEM_WDATA(mem_wdata), .MEM_RDATA(mem_rdata), .CONFLICT_CNT(conflict_cnt)
  );

  // Advance one clock; tracks the expected conflict count across the edge.
  task automatic tick;
    if (rst) exp_conf = 16'd0;
    else if (cpu_req && dbg_req && exp_conf != 16'hFFFF) exp_conf = exp_conf + 16'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    cpu_req = 0; cpu_we = 0; dbg_req = 0; dbg_we = 0; dbg_lock = 0;
  endtask

  task automatic test_reset;
    rst = 1; idle();
    cpu_be = 0; cpu_addr = 0; cpu_wdata = 0; dbg_be = 0; dbg_addr = 0; dbg_wdata = 0;
    mem_rdata = 0;
    #1;
    cpu_req = 1; dbg_req = 1; dbg_lock = 1;
    #1;
    checks++; if (cpu_gnt !== 1'b0 || dbg_gnt !== 1'b0) begin errors++;
      $display("FAIL reset_gnt cpu=%b dbg=%b expected 0 0", cpu_gnt, dbg_gnt); end
    checks++; if (cpu_stall !== 1'b1) begin errors++;
      $display("FAIL reset_stall got %b expected 1", cpu_stall); end
    checks++; if (mem_re !== 1'b0 || mem_we !== 1'b0) begin errors++;
      $display("FAIL reset_mem re=%b we=%b expected 0 0", mem_re, mem_we); end
    checks++; if (conflict_cnt !== 16'd0 || cpu_rvalid !== 1'b0 || dbg_rvalid !== 1'b0) begin errors++;
      $display("FAIL reset_regs cnt=%h crv=%b drv=%b expected 0 0 0", conflict_cnt, cpu_rvalid, dbg_rvalid); end
    tick();
    tick();
    checks++; if (conflict_cnt !== 16'd0) begin errors++;
      $display("FAIL reset_cnt_hold got %h expected 0", conflict_cnt); end
    rst = 0; idle();
    #1;
  endtask

  task automatic test_cpu_read;
    cpu_req = 1; cpu_we = 0; cpu_addr = 30'h10; cpu_be = 4'hF;
    #1;
    checks++; if (cpu_gnt !== 1'b1 || dbg_gnt !== 1'b0 || cpu_stall !== 1'b0) begin errors++;
      $display("FAIL cpu_read_gnt cpu=%b dbg=%b stall=%b expected 1 0 0", cpu_gnt, dbg_gnt, cpu_stall); end
    checks++; if (mem_re !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 30'h10) begin errors++;
      $display("FAIL cpu_read_mem re=%b we=%b addr=%h expected 1 0 10", mem_re, mem_we, mem_addr); end
    tick();
    cpu_req = 0; mem_rdata = 32'hDEADBEEF;
    #1;
    checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hDEADBEEF || dbg_rvalid !== 1'b0) begin errors++;
      $display("FAIL cpu_read_data rv=%b data=%h drv=%b expected 1 deadbeef 0", cpu_rvalid, cpu_rdata, dbg_rvalid); end
    tick();
    checks++; if (cpu_rvalid !== 1'b0) begin errors++;
      $display("FAIL cpu_read_rv_drop got %b expected 0", cpu_rvalid); end
  endtask

  task automatic test_cpu_write;
    cpu_addr = 30'h55; dbg_addr = 30'h77;
    #1;
    checks++; if (mem_addr !== 30'h55 || mem_re !== 1'b0 || mem_we !== 1'b0) begin errors++;
      $display("FAIL idle_mem addr=%h re=%b we=%b expected 55 0 0", mem_addr, mem_re, mem_we); end
    cpu_req = 1; cpu_we = 1; cpu_be = 4'b0011; cpu_addr = 30'h20; cpu_wdata = 32'h12345678;
    dbg_be = 4'b1100; dbg_wdata = 32'hCAFEF00D;
    #1;
    checks++; if (mem_we !== 1'b1 || mem_re !== 1'b0 || mem_be !== 4'b0011 ||
                  mem_addr !== 30'h20 || mem_wdata !== 32'h12345678) begin errors++;
      $display("FAIL cpu_write_mem we=%b re=%b be=%b addr=%h wd=%h expected 1 0 0011 20 12345678",
               mem_we, mem_re, mem_be, mem_addr, mem_wdata); end
    tick();
    idle();
    #1;
    checks++; if (cpu_rvalid !== 1'b0 || dbg_rvalid !== 1'b0) begin errors++;
      $display("FAIL cpu_write_norv crv=%b drv=%b expected 0 0", cpu_rvalid, dbg_rvalid); end
    tick();
  endtask

  task automatic test_starve;
    logic exp_d, prev_d;
    cpu_req = 1; cpu_we = 0; dbg_req = 1; dbg_we = 0; dbg_lock = 0;
    cpu_addr = 30'h100; dbg_addr = 30'h200;
    prev_d = 0;
    #1;
    for (int k = 0; k < 10; k++) begin
      exp_d = (k % 5 == 4);
      checks++; if (dbg_gnt !== exp_d || cpu_gnt !== !exp_d) begin errors++;
        $display("FAIL starve_gnt k=%0d cpu=%b dbg=%b expected dbg=%b", k, cpu_gnt, dbg_gnt, exp_d); end
      checks++; if (mem_addr !== (exp_d ? 30'h200 : 30'h100)) begin errors++;
        $display("FAIL starve_addr k=%0d got %h expected dbg=%b", k, mem_addr, exp_d); end
      checks++; if (conflict_cnt !== exp_conf) begin errors++;
        $display("FAIL starve_conf k=%0d got %0d expected %0d", k, conflict_cnt, exp_conf); end
      if (k > 0) begin
        checks++; if (dbg_rvalid !== prev_d || cpu_rvalid !== !prev_d) begin errors++;
          $display("FAIL b2b_rvalid k=%0d crv=%b drv=%b expected drv=%b", k, cpu_rvalid, dbg_rvalid, prev_d); end
      end
      prev_d = exp_d;
      tick();
    end
    checks++; if (conflict_cnt !== 16'd10) begin errors++;
      $display("FAIL starve_conf_total got %0d expected 10", conflict_cnt); end
    idle();
    tick();
  endtask

  task automatic test_lock;
    cpu_req = 1; dbg_req = 1; dbg_lock = 1;
    #1;
    for (int j = 0; j < 10; j++) begin
      if (j == 8) dbg_lock = 0;
      if (j == 9) begin dbg_req = 0; dbg_lock = 0; end
      #1;
      checks++; if (dbg_gnt !== (j >= 4 && j <= 8) || cpu_gnt !== (j < 4 || j == 9)) begin errors++;
        $display("FAIL lock_gnt j=%0d cpu=%b dbg=%b", j, cpu_gnt, dbg_gnt); end
      checks++; if (cpu_stall !== (j >= 4 && j <= 8)) begin errors++;
        $display("FAIL lock_stall j=%0d got %b", j, cpu_stall); end
      tick();
    end
    idle();
    tick();
  endtask

  task automatic test_reset_mid_read;
    dbg_req = 1; dbg_we = 0; dbg_lock = 1; dbg_addr = 30'h3C;
    #1;
    checks++; if (dbg_gnt !== 1'b1 || mem_re !== 1'b1 || mem_addr !== 30'h3C) begin errors++;
      $display("FAIL dbg_read gnt=%b re=%b addr=%h expected 1 1 3c", dbg_gnt, mem_re, mem_addr); end
    tick();
    idle();
    rst = 1; exp_conf = 0;
    #1;
    checks++; if (dbg_rvalid !== 1'b0 || conflict_cnt !== 16'd0) begin errors++;
      $display("FAIL rst_mid_read drv=%b cnt=%h expected 0 0", dbg_rvalid, conflict_cnt); end
    tick();
    rst = 0;
    cpu_req = 1; dbg_req = 1; dbg_lock = 1;
    #1;
    checks++; if (cpu_gnt !== 1'b1 || dbg_gnt !== 1'b0) begin errors++;
      $display("FAIL rst_arb cpu=%b dbg=%b expected 1 0", cpu_gnt, dbg_gnt); end
    tick();
    checks++; if (dbg_rvalid !== 1'b0 || cpu_rvalid !== 1'b1) begin errors++;
      $display("FAIL rst_no_replay drv=%b crv=%b expected 0 1", dbg_rvalid, cpu_rvalid); end
    idle();
    tick();
  endtask

  task automatic test_saturate;
    cpu_req = 1; dbg_req = 1; dbg_lock = 0;
    #1;
    for (int i = 0; i < 70000; i++) begin
      tick();
      if (i == 100) begin
        checks++; if (conflict_cnt !== exp_conf) begin errors++;
          $display("FAIL sat_mid got %0d expected %0d", conflict_cnt, exp_conf); end
      end
    end
    checks++; if (conflict_cnt !== 16'hFFFF) begin errors++;
      $display("FAIL sat_hold got %h expected ffff", conflict_cnt); end
    tick();
    checks++; if (conflict_cnt !== 16'hFFFF) begin errors++;
      $display("FAIL sat_hold2 got %h expected ffff", conflict_cnt); end
    idle();
    tick();
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_starve();
    test_lock();
    test_reset_mid_read();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
